axis_sample_source: RTL and testbench
=====================================

AXIS_SAMPLE_SOURCE -- requirements
Module: axis_sample_source

Interface
REQ-001 The module SHALL have parameter DIN_W, default 12, width of the raw signed sample input.
REQ-002 The module SHALL have parameter AXIS_W, default 16, width of the AXI-Stream tdata (AXIS_W >= DIN_W).
REQ-003 The module SHALL have parameter DEPTH, default 4, FIFO depth in samples (power of two, >= 2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 din_valid  input  1  sample strobe; one sample per high cycle.
REQ-007 din  input  DIN_W  signed two's-complement sample.
REQ-008 m_axis_data_tvalid  output  1  AXI-Stream valid to the FIR IP slave port.
REQ-009 m_axis_data_tready  input  1  AXI-Stream ready from the FIR IP.
REQ-010 m_axis_data_tdata  output  AXIS_W  sign-extended sample.
REQ-011 clr_ovf  input  1  clears the sticky overflow flag.
REQ-012 overflow  output  1  sticky flag: a sample was dropped.
REQ-013 level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-014 sample_cnt  output  16  count of completed AXI transfers, wraps 0xFFFF->0x0000.

Function
REQ-015 A push SHALL occur when din_valid=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-016 The pushed word SHALL be din sign-extended to AXIS_W ({(AXIS_W-DIN_W){din[DIN_W-1]}, din}).
REQ-017 A pop SHALL occur when m_axis_data_tvalid=1 and m_axis_data_tready=1.
REQ-018 m_axis_data_tvalid SHALL equal (level!=0); it SHALL NOT depend combinationally on m_axis_data_tready.
REQ-019 Latency: a sample pushed into an empty FIFO in cycle N SHALL appear on tdata with tvalid=1 in cycle N+1.
REQ-020 While tvalid=1 and tready=0, tdata SHALL remain stable and tvalid SHALL remain 1.
REQ-021 Samples SHALL be delivered in arrival order with no duplication.
REQ-022 Simultaneous push and pop SHALL leave level unchanged, including at level=DEPTH (full) and at level=1.
REQ-023 din_valid=1 with level=DEPTH and no pop SHALL drop the sample, leave FIFO contents unchanged, and set overflow the next cycle.
REQ-024 overflow SHALL remain 1 until clr_ovf=1; if set and clear coincide, set SHALL win.
REQ-025 sample_cnt SHALL increment by 1 on each pop and wrap modulo 2^16.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be a registered counter, never derived from the pointers alone.
REQ-027 tready held at 1 with din_valid every cycle SHALL sustain one transfer per cycle with level<=1.

Reset
REQ-028 On rst=0, asynchronously: level=0, pointers=0, m_axis_data_tvalid=0, overflow=0, sample_cnt=0; tdata content is don't-care but deterministic (0).
REQ-029 Reset asserted mid-stream SHALL discard all buffered samples; no transfer SHALL occur in the first cycle after release unless a push happened in that cycle.
REQ-030 FIFO storage array SHALL NOT require reset.

Structure
REQ-031 A shared package SHALL hold DIN_W/AXIS_W/DEPTH defaults, the sample-count width (16), and the sign-extension function.
REQ-032 Storage and pointer logic SHALL be one sub-module, axis_src_fifo (synchronous, first-word fall-through, registered level).
REQ-033 Top level SHALL contain only push/pop qualification, sign extension, overflow flag and sample counter.

Verification
REQ-034 Reset then din_valid=1, din=12'h7FF in cycle 0, tready=1 -> cycle 1 tvalid=1, tdata=16'h07FF; cycle 2 tvalid=0, sample_cnt=1.
REQ-035 din=12'h800 and 12'hFFF pushed -> tdata 16'hF800 then 16'hFFFF in order.
REQ-036 tready=0, push 5 samples 1..5 -> level 4, samples 1..4 held, overflow=1; tready=1 -> 1,2,3,4 delivered, then tvalid=0, sample_cnt=4.
REQ-037 Full FIFO, tready=1 and din_valid=1 same cycle -> level stays 4, overflow stays 0, new sample delivered after the 3 older ones.
REQ-038 overflow=1, clr_ovf=1 coinciding with a dropped push -> overflow remains 1; clr_ovf alone next cycle -> overflow=0.
REQ-039 Stream 65537 samples at tready=1 -> sample_cnt wraps to 1; mid-stream rst=0 pulse -> tvalid=0, level=0, sample_cnt=0 immediately.

Source files
------------

// File: rtl/axis_sample_source_pkg.sv
// Shared definitions for the AXI-Stream sample source: default widths,
// the transfer-counter width and the sample sign-extension helper.
package axis_sample_source_pkg;

    localparam int DIN_W_DEF  = 12;
    localparam int AXIS_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int CNT_W      = 16;

    // Widest raw/extended sample the helper below can carry.
    localparam int SEXT_W     = 64;

    // Replicate bit (width-1) of raw into every bit at or above width.
    function automatic logic [SEXT_W-1:0] sign_ext(input logic [SEXT_W-1:0] raw,
                                                   input int                width);
        logic [SEXT_W-1:0] ext;
        ext = raw;
        for (int i = 0; i < SEXT_W; i++) begin
            if (i >= width) begin
                ext[i] = raw[width-1];
            end
        end
        return ext;
    endfunction

endpackage

// File: rtl/axis_src_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy
// counter. The head word is visible on rdata whenever level is non-zero.
module axis_src_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Empty FIFO presents zero so the output is deterministic out of reset.
    assign rdata = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/axis_sample_source.sv
// Feeds raw signed samples into an AXI-Stream master port through a small
// FIFO. Samples arriving while the FIFO is full (and not draining) are
// dropped and flagged on a sticky overflow bit; completed transfers are
// counted modulo 2^16.
module axis_sample_source
    import axis_sample_source_pkg::*;
#(
    parameter  int DIN_W  = DIN_W_DEF,
    parameter  int AXIS_W = AXIS_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [DIN_W-1:0] din,
    output logic                    m_axis_data_tvalid,
    input  logic                    m_axis_data_tready,
    output logic [AXIS_W-1:0]       m_axis_data_tdata,
    input  logic                    clr_ovf,
    output logic                    overflow,
    output logic [LVL_W-1:0]        level,
    output logic [CNT_W-1:0]        sample_cnt
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic              push;
    logic              pop;
    logic              drop;
    logic [AXIS_W-1:0] din_ext;

    // tvalid comes straight from the registered level, never from tready.
    assign m_axis_data_tvalid = (level != '0);
    assign pop  = m_axis_data_tvalid && m_axis_data_tready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push = din_valid && ((level < FULL_LVL) || pop);
    assign drop = din_valid && !push;

    assign din_ext = AXIS_W'(sign_ext(SEXT_W'(din), DIN_W));

    axis_src_fifo #(
        .WIDTH (AXIS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (din_ext),
        .rdata (m_axis_data_tdata),
        .level (level)
    );

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Completed-transfer counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt <= '0;
        end else if (pop) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_sample_source.sv
// Scoreboard bench for axis_sample_source: accepted samples are queued as
// expected words and compared as the DUT presents them on the stream port.
module tb_axis_sample_source;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [11:0] din = '0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [15:0] tdata;
    logic        clr_ovf = 1'b0;
    logic        overflow;
    logic [2:0]  level;
    logic [15:0] sample_cnt;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [15:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    axis_sample_source dut (
        .clk                (clk),
        .rst                (rst),
        .din_valid          (din_valid),
        .din                (din),
        .m_axis_data_tvalid (tvalid),
        .m_axis_data_tready (tready),
        .m_axis_data_tdata  (tdata),
        .clr_ovf            (clr_ovf),
        .overflow           (overflow),
        .level              (level),
        .sample_cnt         (sample_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, compare outputs against the model,
    // advance the model by one clock and step to the next posedge+1.
    task automatic cycle(input bit dv, input logic [11:0] d, input bit rdy, input bit clr);
        bit do_pop;
        bit do_push;
        din_valid = dv;
        din       = d;
        tready    = rdy;
        clr_ovf   = clr;
        #1;
        check("tvalid", 32'(tvalid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("tdata", 32'(tdata), 32'(exp_q[0]));
        check("level", 32'(level), 32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
        do_pop  = (exp_q.size() != 0) && rdy;
        do_push = dv && ((exp_q.size() < DEPTH) || do_pop);
        if (do_pop) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
        end
        if (do_push) exp_q.push_back({{4{d[11]}}, d});
        if (dv && !do_push) exp_ovf = 1'b1;
        else if (clr)       exp_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse applied between clock edges.
    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_pulse();

        // Single sample with immediate pop.
        cycle(1, 12'h7FF, 1, 0);
        check("first_tdata", 32'(tdata), 32'h07FF);
        cycle(0, 12'h000, 1, 0);
        cycle(0, 12'h000, 1, 0);
        check("first_cnt", 32'(sample_cnt), 32'd1);

        // Negative extremes keep order and sign.
        cycle(1, 12'h800, 1, 0);
        cycle(1, 12'hFFF, 1, 0);
        cycle(0, 12'h000, 1, 0);
        cycle(0, 12'h000, 1, 0);

        // Fill with back-pressure, overflow on the fifth sample, then drain.
        for (int i = 1; i <= 5; i++) cycle(1, 12'(i), 0, 0);
        check("full_level", 32'(level), 32'd4);
        check("full_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) cycle(0, 12'h000, 1, 0);
        check("drain_cnt", 32'(sample_cnt), 32'd7);

        // Clear coinciding with a drop leaves overflow set; lone clear clears it.
        for (int i = 0; i < 4; i++) cycle(1, 12'(16 + i), 0, 0);
        cycle(1, 12'h0AA, 0, 1);
        cycle(0, 12'h000, 0, 1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        cycle(1, 12'h123, 1, 0);
        check("fullpp_level", 32'(level), 32'd4);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 5; i++) cycle(0, 12'h000, 1, 0);

        // Random mix of strobes, back-pressure and clears.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0));
        for (int i = 0; i < 5; i++) cycle(0, 12'h000, 1, 1);

        // Mid-stream reset with data buffered.
        for (int i = 0; i < 3; i++) cycle(1, 12'(40 + i), 0, 0);
        reset_pulse();
        cycle(0, 12'h000, 1, 0);

        // Continuous streaming: 65537 transfers wrap the counter to 1.
        for (int i = 0; i < 65537; i++) cycle(1, 12'(i), 1, 0);
        cycle(0, 12'h000, 1, 0);
        check("cnt_wrap", 32'(sample_cnt), 32'd1);
        check("stream_empty", 32'(tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
